// File: rtl/spram_pkg.sv
// Shared types and widths for the UP5K single-port RAM arbiter.
// The RAM is one SB_SPRAM256KA: 16K words x 16 bits with nibble write enables.
package spram_pkg;
    localparam int SPRAM_AW = 14;
    localparam int SPRAM_DW = 16;
    localparam int SPRAM_MW = 4;
    localparam int RD_LAT   = 2;

    typedef enum logic [1:0] {ACTIVE, STANDBY, WAKE} spram_state_t;

    typedef logic port_id_t;

    typedef struct packed {
        logic                write;
        logic [SPRAM_AW-1:0] addr;
        logic [SPRAM_DW-1:0] wdata;
        logic [SPRAM_MW-1:0] mask;
    } spram_req_t;
endpackage

// File: rtl/spram_rr_arb.sv
// Two-way grant logic: round-robin on last_grant, or port 0 always wins
// contention when FIXED_PRIORITY is set. The grant is purely combinational.
module spram_rr_arb
    import spram_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);
    port_id_t r_last_grant;

    always_comb begin
        o_grant = 2'b00;
        unique case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = ((FIXED_PRIORITY != 0) || (r_last_grant == 1'b1)) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Reset to port 1 so that port 0 wins the first contest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_last_grant <= 1'b1;
        else if (|o_grant)
            r_last_grant <= o_grant[1];
    end
endmodule

// File: rtl/spram_arbiter.sv
// Shares one SPRAM between a CPU port and a display/DMA port: one access per
// cycle, read data returned two cycles after accept, standby when idle.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter int IDLE_CYCLES    = 64,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic                req0_write,
    input  logic [SPRAM_AW-1:0] req0_addr,
    input  logic [SPRAM_DW-1:0] req0_wdata,
    input  logic [SPRAM_MW-1:0] req0_mask,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic                req1_write,
    input  logic [SPRAM_AW-1:0] req1_addr,
    input  logic [SPRAM_DW-1:0] req1_wdata,
    input  logic [SPRAM_MW-1:0] req1_mask,
    output logic                rsp0_valid,
    output logic                rsp1_valid,
    output logic [SPRAM_DW-1:0] rsp_rdata,
    output logic [SPRAM_AW-1:0] ram_addr,
    output logic [SPRAM_DW-1:0] ram_datain,
    output logic [SPRAM_MW-1:0] ram_maskwren,
    output logic                ram_wren,
    output logic                ram_cs,
    output logic                ram_standby,
    input  logic [SPRAM_DW-1:0] ram_dataout
);
    localparam int            CW        = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] IDLE_LAST = CW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);

    spram_state_t        r_state, w_state_nxt;
    logic [CW-1:0]       r_idle_cnt;
    logic                r_standby;
    logic [SPRAM_AW-1:0] r_addr;
    logic [SPRAM_DW-1:0] r_datain;
    logic [SPRAM_MW-1:0] r_maskwren;
    logic                r_wren, r_cs;
    logic [RD_LAT:1]     r_vld_pipe;
    logic [RD_LAT:1]     r_pid_pipe;

    logic [1:0]          w_req, w_grant;
    logic                w_accept, w_any_valid, w_in_flight;
    spram_req_t          w_req0, w_req1, w_sel;

    assign w_req0      = '{write: req0_write, addr: req0_addr, wdata: req0_wdata, mask: req0_mask};
    assign w_req1      = '{write: req1_write, addr: req1_addr, wdata: req1_wdata, mask: req1_mask};
    assign w_any_valid = req0_valid | req1_valid;
    assign w_req       = {req1_valid, req0_valid} & {2{r_state == ACTIVE}};
    assign w_accept    = |w_grant;
    assign w_sel       = w_grant[1] ? w_req1 : w_req0;
    assign w_in_flight = |r_vld_pipe;

    spram_rr_arb #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .i_req   (w_req),
        .o_grant (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // Standby only once the RAM has delivered every outstanding read.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACTIVE:  if ((IDLE_CYCLES != 0) && (r_idle_cnt == IDLE_LAST) && !w_any_valid && !w_in_flight)
                         w_state_nxt = STANDBY;
            STANDBY: if (w_any_valid) w_state_nxt = WAKE;
            WAKE:    w_state_nxt = ACTIVE;
            default: w_state_nxt = ACTIVE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ACTIVE;
            r_standby <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_standby <= (w_state_nxt == STANDBY);
        end
    end

    // Saturates at IDLE_LAST so a long in-flight stall cannot skip the match.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_idle_cnt <= '0;
        else if ((r_state != ACTIVE) || w_accept)
            r_idle_cnt <= '0;
        else if (r_idle_cnt != IDLE_LAST)
            r_idle_cnt <= r_idle_cnt + CW'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_datain   <= '0;
            r_maskwren <= '0;
            r_wren     <= 1'b0;
            r_cs       <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= w_sel.addr;
            r_datain   <= w_sel.wdata;
            r_maskwren <= w_sel.write ? w_sel.mask : '0;
            r_wren     <= w_sel.write;
            r_cs       <= 1'b1;
        end else begin
            r_wren     <= 1'b0;
            r_cs       <= 1'b0;
        end
    end

    // Port tag travels with each read until the RAM output is valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_pid_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[RD_LAT-1:1], w_accept & ~w_sel.write};
            r_pid_pipe <= {r_pid_pipe[RD_LAT-1:1], w_grant[1]};
        end
    end

    assign rsp0_valid   = r_vld_pipe[RD_LAT] & ~r_pid_pipe[RD_LAT];
    assign rsp1_valid   = r_vld_pipe[RD_LAT] &  r_pid_pipe[RD_LAT];
    assign rsp_rdata    = ram_dataout;
    assign ram_addr     = r_addr;
    assign ram_datain   = r_datain;
    assign ram_maskwren = r_maskwren;
    assign ram_wren     = r_wren;
    assign ram_cs       = r_cs;
    assign ram_standby  = r_standby;
endmodule
